// File: rtl/fir_tap_sequencer.sv
// Tap-loop sequencer for the FP16 FIR: owns the delay-line write pointer, walks the
// taps issuing delay/coefficient read addresses and MAC strobes, and arbitrates coefficient loads.
module fir_tap_sequencer #(
    parameter int MAC_LAT    = 3,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  in_ready,
    input  logic [6:0]            ntaps,
    input  logic                  cload,
    input  logic [DEPTH_LOG2-1:0] caddr,
    output logic                  cload_ready,
    output logic                  cwe,
    output logic [DEPTH_LOG2-1:0] cwaddr,
    output logic                  dwe,
    output logic [DEPTH_LOG2-1:0] dwaddr,
    output logic [DEPTH_LOG2-1:0] rd_daddr,
    output logic [DEPTH_LOG2-1:0] rd_caddr,
    output logic                  mac_en,
    output logic                  mac_clr,
    output logic                  mac_last,
    output logic                  valid,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int AW = DEPTH_LOG2;
    localparam logic [6:0] DEPTH_N    = 7'(1 << DEPTH_LOG2);
    localparam logic [3:0] DRAIN_LAST = (MAC_LAT > 0) ? 4'(MAC_LAT - 1) : 4'd0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] base_q, base_d;
    logic [6:0]    n_q, n_d;
    logic [6:0]    k_q, k_d;
    logic [3:0]    drain_q, drain_d;
    logic [AW-1:0] rd_daddr_q, rd_daddr_d;
    logic [AW-1:0] rd_caddr_q, rd_caddr_d;
    logic          mac_en_q, mac_en_d;
    logic          mac_clr_q, mac_clr_d;
    logic          mac_last_q, mac_last_d;
    logic          valid_q, valid_d;
    logic [6:0]    eff_n;
    logic          idle;

    // Coefficient load has priority over a sample when both arrive while idle.
    assign idle        = (state_q == ST_IDLE);
    assign cload_ready = idle;
    assign in_ready    = idle & ~cload;
    assign cwe         = cload & idle;
    assign cwaddr      = caddr;
    assign dwe         = valid_in & in_ready;
    assign dwaddr      = wptr_q;
    assign eff_n       = ((ntaps == 7'd0) || (ntaps > DEPTH_N)) ? DEPTH_N : ntaps;

    assign rd_daddr  = rd_daddr_q;
    assign rd_caddr  = rd_caddr_q;
    assign mac_en    = mac_en_q;
    assign mac_clr   = mac_clr_q;
    assign mac_last  = mac_last_q;
    assign valid     = valid_q;
    assign busy      = ~idle;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        base_d     = base_q;
        n_d        = n_q;
        k_d        = k_q;
        drain_d    = drain_q;
        rd_daddr_d = rd_daddr_q;
        rd_caddr_d = rd_caddr_q;
        mac_en_d   = 1'b0;
        mac_clr_d  = 1'b0;
        mac_last_d = 1'b0;
        valid_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dwe) begin
                    // The tap-0 strobes are set up here so they appear in the first RUN cycle.
                    base_d     = wptr_q;
                    n_d        = eff_n;
                    wptr_d     = wptr_q + 1'b1;
                    k_d        = 7'd0;
                    state_d    = ST_RUN;
                    rd_daddr_d = wptr_q;
                    rd_caddr_d = '0;
                    mac_en_d   = 1'b1;
                    mac_clr_d  = 1'b1;
                    mac_last_d = (eff_n == 7'd1);
                end
            end
            ST_RUN: begin
                if (k_q == n_q - 7'd1) begin
                    if (MAC_LAT == 0) begin
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        drain_d = 4'd0;
                        state_d = ST_DRAIN;
                    end
                end else begin
                    k_d        = k_q + 7'd1;
                    rd_daddr_d = base_q - AW'(k_q + 7'd1);
                    rd_caddr_d = AW'(k_q + 7'd1);
                    mac_en_d   = 1'b1;
                    mac_last_d = (k_q + 7'd2 == n_q);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    valid_d = 1'b1;
                    drain_d = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            base_q     <= '0;
            n_q        <= 7'd0;
            k_q        <= 7'd0;
            drain_q    <= 4'd0;
            rd_daddr_q <= '0;
            rd_caddr_q <= '0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_last_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            base_q     <= base_d;
            n_q        <= n_d;
            k_q        <= k_d;
            drain_q    <= drain_d;
            rd_daddr_q <= rd_daddr_d;
            rd_caddr_q <= rd_caddr_d;
            mac_en_q   <= mac_en_d;
            mac_clr_q  <= mac_clr_d;
            mac_last_q <= mac_last_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: a fixed vector table for one run, directed corner
// sequences, and random traffic, all compared against a schedule-level reference model.
module tb_fir_tap_sequencer;

    localparam int MAC_LAT = 3;

    logic       clk1 = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [6:0] ntaps = 7'd4;
    logic       cload = 1'b0;
    logic [5:0] caddr = 6'd0;
    logic       in_ready, cload_ready, cwe, dwe;
    logic [5:0] cwaddr, dwaddr, rd_daddr, rd_caddr;
    logic       mac_en, mac_clr, mac_last, valid, busy;
    logic [1:0] dbg_state;

    always #5 clk1 = ~clk1;

    fir_tap_sequencer #(.MAC_LAT(MAC_LAT), .DEPTH_LOG2(6)) dut (
        .clk1(clk1), .rst(rst), .valid_in(valid_in), .in_ready(in_ready),
        .ntaps(ntaps), .cload(cload), .caddr(caddr), .cload_ready(cload_ready),
        .cwe(cwe), .cwaddr(cwaddr), .dwe(dwe), .dwaddr(dwaddr),
        .rd_daddr(rd_daddr), .rd_caddr(rd_caddr), .mac_en(mac_en),
        .mac_clr(mac_clr), .mac_last(mac_last), .valid(valid), .busy(busy),
        .dbg_state(dbg_state)
    );

    typedef struct {
        logic       vin;
        logic       cl;
        logic [6:0] nt;
        logic       e_dwe;
        logic [5:0] e_rdd;
        logic [5:0] e_rdc;
        logic       e_en;
        logic       e_clr;
        logic       e_last;
        logic       e_valid;
        logic       e_busy;
    } vec_t;

    vec_t tab[10];
    vec_t nil_v;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: each acceptance defines a schedule relative to its cycle.
    int cyc = 0;
    bit have_acc = 0;
    int acc_t = 0;
    int m_base = 0;
    int m_n = 0;
    int m_wptr = 0;
    int acc_cnt = 0;
    bit m_idle = 1;
    int dut_last_dwaddr = -1;
    int mac_en_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        int rel, k;
        int e_rdd, e_rdc, e_en, e_clr, e_last, e_valid, e_busy;
        e_rdd = 0; e_rdc = 0; e_en = 0; e_clr = 0; e_last = 0; e_valid = 0; e_busy = 0;
        if (have_acc) begin
            rel = cyc - acc_t;
            if (rel >= 1 && rel <= m_n) begin
                k      = rel - 1;
                e_en   = 1;
                e_clr  = (k == 0);
                e_last = (k == m_n - 1);
                e_rdd  = (m_base - k) & 63;
                e_rdc  = k;
            end else if (rel > m_n) begin
                e_rdd = (m_base - (m_n - 1)) & 63;
                e_rdc = m_n - 1;
            end
            e_valid = (rel == m_n + MAC_LAT + 1);
            e_busy  = (rel >= 1 && rel <= m_n + MAC_LAT);
        end
        m_idle = (e_busy == 0);
        chk("cload_ready", {31'd0, cload_ready}, {31'd0, m_idle});
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_idle & ~cload});
        chk("cwe", {31'd0, cwe}, {31'd0, m_idle & cload});
        chk("cwaddr", {26'd0, cwaddr}, {26'd0, caddr});
        chk("dwe", {31'd0, dwe}, {31'd0, m_idle & ~cload & valid_in});
        chk("dwaddr", {26'd0, dwaddr}, m_wptr);
        chk("rd_daddr", {26'd0, rd_daddr}, e_rdd);
        chk("rd_caddr", {26'd0, rd_caddr}, e_rdc);
        chk("mac_en", {31'd0, mac_en}, e_en);
        chk("mac_clr", {31'd0, mac_clr}, e_clr);
        chk("mac_last", {31'd0, mac_last}, e_last);
        chk("valid", {31'd0, valid}, e_valid);
        chk("busy", {31'd0, busy}, e_busy);
        if (dwe === 1'b1) dut_last_dwaddr = int'(dwaddr);
        if (mac_en === 1'b1) mac_en_cnt++;
    endtask

    task automatic model_update();
        if (rst) begin
            have_acc = 0;
            m_wptr   = 0;
        end else if (valid_in && !cload && m_idle) begin
            acc_t  = cyc;
            m_base = m_wptr;
            m_n    = (ntaps == 0 || ntaps > 64) ? 64 : int'(ntaps);
            m_wptr = (m_wptr + 1) % 64;
            have_acc = 1;
            acc_cnt++;
        end
        cyc++;
    endtask

    task automatic tick(input bit use_tab, input vec_t v);
        @(negedge clk1);
        check_model();
        if (use_tab) begin
            chk("tab_dwe", {31'd0, dwe}, {31'd0, v.e_dwe});
            chk("tab_rd_daddr", {26'd0, rd_daddr}, {26'd0, v.e_rdd});
            chk("tab_rd_caddr", {26'd0, rd_caddr}, {26'd0, v.e_rdc});
            chk("tab_mac_en", {31'd0, mac_en}, {31'd0, v.e_en});
            chk("tab_mac_clr", {31'd0, mac_clr}, {31'd0, v.e_clr});
            chk("tab_mac_last", {31'd0, mac_last}, {31'd0, v.e_last});
            chk("tab_valid", {31'd0, valid}, {31'd0, v.e_valid});
            chk("tab_busy", {31'd0, busy}, {31'd0, v.e_busy});
        end
        @(posedge clk1);
        model_update();
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, nil_v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        cload = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic accept_one(input logic [6:0] nt);
        int start, budget;
        start = acc_cnt;
        budget = 0;
        ntaps = nt;
        valid_in = 1'b1;
        while (acc_cnt == start && budget < 300) begin
            tick(1'b0, nil_v);
            budget++;
        end
        valid_in = 1'b0;
        chk("accept_timeout", acc_cnt - start, 1);
    endtask

    initial begin
        nil_v = '{1'b0, 1'b0, 7'd0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[0] = '{1'b1, 1'b0, 7'd4, 1'b1, 6'd0,  6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[1] = '{1'b0, 1'b0, 7'd4, 1'b0, 6'd0,  6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tab[2] = '{1'b0, 1'b0, 7'd4, 1'b0, 6'd63, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[3] = '{1'b0, 1'b0, 7'd4, 1'b0, 6'd62, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[4] = '{1'b0, 1'b0, 7'd4, 1'b0, 6'd61, 6'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tab[5] = '{1'b0, 1'b0, 7'd4, 1'b0, 6'd61, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[6] = '{1'b0, 1'b0, 7'd4, 1'b0, 6'd61, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[7] = '{1'b0, 1'b0, 7'd4, 1'b0, 6'd61, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[8] = '{1'b0, 1'b0, 7'd4, 1'b0, 6'd61, 6'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[9] = '{1'b0, 1'b0, 7'd4, 1'b0, 6'd61, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Power-up reset without checks, then the table run from wptr=0.
        repeat (2) @(posedge clk1);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            valid_in = tab[i].vin;
            cload    = tab[i].cl;
            ntaps    = tab[i].nt;
            tick(1'b1, tab[i]);
        end

        // Coefficient load burst with a pending sample that must stay stalled.
        do_reset();
        valid_in = 1'b1;
        for (int i = 0; i < 64; i++) begin
            cload = 1'b1;
            caddr = 6'(i);
            tick(1'b0, nil_v);
        end
        cload = 1'b0;
        valid_in = 1'b0;
        step(1);

        // Collision: load wins, sample accepted the following cycle.
        valid_in = 1'b1;
        cload = 1'b1;
        caddr = 6'd17;
        ntaps = 7'd3;
        tick(1'b0, nil_v);
        cload = 1'b0;
        tick(1'b0, nil_v);
        valid_in = 1'b0;
        step(10);

        // 65 samples with ntaps=2: last write wraps to address 0.
        do_reset();
        for (int i = 0; i < 65; i++) accept_one(7'd2);
        chk("wrap_dwaddr", dut_last_dwaddr, 0);
        step(8);

        // Out-of-range tap counts behave like 64 taps.
        mac_en_cnt = 0;
        accept_one(7'd0);
        step(70);
        chk("ntaps0_mac_cycles", mac_en_cnt, 64);
        mac_en_cnt = 0;
        accept_one(7'd100);
        step(70);
        chk("ntaps100_mac_cycles", mac_en_cnt, 64);

        // Reset during RUN at tap k=2.
        accept_one(7'd8);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(15);
        accept_one(7'd2);
        chk("post_abort_dwaddr", dut_last_dwaddr, 0);
        step(8);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            valid_in = 1'($urandom_range(0, 1));
            cload    = ($urandom_range(0, 3) == 0);
            caddr    = 6'($urandom_range(0, 63));
            ntaps    = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127))
                                                   : 7'($urandom_range(0, 6));
            rst      = ($urandom_range(0, 99) == 0);
            tick(1'b0, nil_v);
        end
        rst = 1'b0;
        valid_in = 1'b0;
        cload = 1'b0;
        step(80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Control/sequencing block for the FP16 FIR datapath.
- Owns the 64-entry circular delay-line write pointer and steps the tap loop, emitting delay-RAM and coefficient-RAM read addresses plus MAC control strobes.
- Shares the coefficient RAM write port between host loads and the filter run: loads are only granted while idle.
- Sits between the sample source / host config and the FIR RAMs and FP16 MAC.

Parameters:
- MAC_LAT, 3, pipeline depth of the FP16 MAC (cycles from the mac_last strobe to a settled accumulator). Range 0..15.
- DEPTH_LOG2, 6, log2 of delay-line and coefficient RAM depth (64 entries).

Ports:
- clk1  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  new sample presented to the delay RAM this cycle.
- in_ready  out  1  sample accepted when valid_in & in_ready.
- ntaps  in  7  active tap count; 0 or >64 is treated as 64.
- cload  in  1  host coefficient write request.
- caddr  in  6  host coefficient address.
- cload_ready  out  1  coefficient write granted when cload & cload_ready.
- cwe  out  1  coefficient RAM write enable.
- cwaddr  out  6  coefficient RAM write address.
- dwe  out  1  delay RAM write enable.
- dwaddr  out  6  delay RAM write address.
- rd_daddr  out  6  delay RAM read address.
- rd_caddr  out  6  coefficient RAM read address.
- mac_en  out  1  MAC accumulate this cycle.
- mac_clr  out  1  first tap: load the product instead of accumulating.
- mac_last  out  1  final tap of the current output.
- valid  out  1  one-cycle pulse: MAC output is valid.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, RUN, DRAIN. Reset puts the block in IDLE.
- Reset values: wptr=0, k=0, drain counter=0, and rd_daddr, rd_caddr, mac_en, mac_clr, mac_last, valid, busy all 0.
- After reset, in_ready=cload_ready=1 provided cload is low.
- Reset mid-RUN/DRAIN aborts the run: no valid pulse is produced and wptr returns to 0. RAM contents are not cleared; software flushes the delay line by feeding 64 zero samples.

Combinational outputs:
- cload_ready = (state==IDLE).
- in_ready = (state==IDLE) & ~cload. When both are requested in the same cycle, the coefficient load wins and the sample stalls.
- cwe = cload & cload_ready; cwaddr = caddr.
- dwe = valid_in & in_ready; dwaddr = wptr.

IDLE, on acceptance at cycle T:
- Latch base=wptr.
- Latch N = effective ntaps (1..64).
- wptr <= wptr+1 mod 64; k <= 0; go to RUN.

RUN, cycles T+1 .. T+N; the outputs below are registered:
- In cycle T+1+k: rd_daddr=(base-k) mod 64, rd_caddr=k, mac_en=1.
- mac_clr=1 only when k==0.
- mac_last=1 only when k==N-1.
- k increments each cycle.
- After k==N-1: go to DRAIN, or straight to the valid cycle if MAC_LAT==0.

DRAIN:
- Holds for MAC_LAT cycles with mac_en, mac_clr and mac_last at 0.
- Read addresses hold their last value.

Completion:
- valid=1 for exactly one cycle, at T+N+MAC_LAT+1.
- The state is IDLE in that same cycle, so in_ready may be high and a new sample accepted back-to-back.
- Throughput: one output per N+MAC_LAT+1 cycles.
- ntaps changes during a run have no effect until the next acceptance.
- Address arithmetic is unsigned and wraps modulo 2^DEPTH_LOG2. wptr wraps from 63 to 0.
- valid_in while busy is ignored; the source must hold it until in_ready.
- cload while busy is stalled; the host must hold cload and caddr until cload_ready.

Test Plan:
- Reset, then cload with caddr=0..63 on consecutive cycles -> cwe high for 64 cycles, cwaddr=0..63, in_ready low throughout, busy=0.
- ntaps=4, MAC_LAT=3, sample at T with wptr=0 -> dwe/dwaddr=0 at T. At T+1..T+4: rd_daddr=0,63,62,61 and rd_caddr=0..3, mac_clr only at T+1, mac_last only at T+4. valid at T+8.
- 65 samples with ntaps=2 -> the 65th write has dwaddr=0. The following RUN reads rd_daddr=0 then 63 (wrap).
- valid_in and cload both high in IDLE -> cwe=1, dwe=0, in_ready=0. Next cycle with cload low -> sample accepted.
- ntaps=0 -> 64 mac_en cycles with rd_caddr 0..63. ntaps=100 -> same as 64. valid arrives 64+MAC_LAT+1 cycles after acceptance.
- rst asserted at RUN tap k=2 -> next cycle all outputs 0, state IDLE, no valid pulse. The next sample is written at dwaddr=0.
